// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: opcodes, instruction
// field positions and the fetch FSM state type.
package instruction_fetch_pkg;

   localparam int INSTR_W = 28;
   localparam int OPC_HI  = 27;
   localparam int OPC_LO  = 24;
   localparam int TGT_HI  = 23;
   localparam int TGT_LO  = 16;

   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_JMP  = 4'h1;
   localparam logic [3:0] OPC_CALL = 4'h2;
   localparam logic [3:0] OPC_RET  = 4'h3;
   localparam logic [3:0] OPC_BLE  = 4'h4;

   typedef enum logic [1:0] {
      ST_FETCH       = 2'd0,
      ST_WAIT_BRANCH = 2'd1,
      ST_HALT        = 2'd2
   } fetch_state_t;

   function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
      return instr[OPC_HI:OPC_LO];
   endfunction

   function automatic logic [7:0] get_target(input logic [INSTR_W-1:0] instr);
      return instr[TGT_HI:TGT_LO];
   endfunction

endpackage

// File: rtl/instruction_fetch_return_stack.sv
// LIFO return-address stack; push is ignored when full and pop when empty,
// the caller is expected to check full/empty first.
module return_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] top
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW:0]      sp_r;
   logic [PW-1:0]    wr_idx_s;
   logic [PW-1:0]    rd_idx_s;

   assign wr_idx_s = sp_r[PW-1:0];
   assign rd_idx_s = wr_idx_s - PW'(1);
   assign full     = (sp_r == (PW+1)'(DEPTH));
   assign empty    = (sp_r == (PW+1)'(0));
   assign top      = mem_r[rd_idx_s];

   // Stack pointer and entry storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_r <= (PW+1)'(0);
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= WIDTH'(0);
         end
      end else if (push && !full) begin
         mem_r[wr_idx_s] <= push_data;
         sp_r            <= sp_r + (PW+1)'(1);
      end else if (pop && !empty) begin
         sp_r <= sp_r - (PW+1)'(1);
      end else begin
         sp_r <= sp_r;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Program counter sequencer: fetches from an external combinational ROM,
// resolves JMP/CALL/RET locally and parks on BLE until execute resolves it.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int STACK_DEPTH = 8,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                  Clock,
   input  logic                  Reset,
   output logic [ADDR_WIDTH-1:0] oAddress,
   input  logic [INSTR_W-1:0]    iInstruction,
   input  logic                  iStall,
   input  logic                  iBranchValid,
   input  logic                  iBranchTaken,
   output logic [INSTR_W-1:0]    oInstruction,
   output logic                  oValid,
   output logic                  oStackOverflow,
   output logic                  oStackUnderflow
);

   fetch_state_t          state_r, state_next_s;
   logic [ADDR_WIDTH-1:0] pc_r, pc_next_s, pc_inc_s, target_s;
   logic [ADDR_WIDTH-1:0] br_target_r, br_fall_r;
   logic [INSTR_W-1:0]    instr_r;
   logic [3:0]            opcode_s;
   logic                  valid_r, valid_next_s, instr_load_s, capture_s;
   logic                  ovf_r, unf_r, ovf_set_s, unf_set_s;
   logic                  push_s, pop_s, stk_full_s, stk_empty_s;
   logic [ADDR_WIDTH-1:0] stk_top_s;

   assign opcode_s = get_opcode(iInstruction);
   assign target_s = ADDR_WIDTH'(get_target(iInstruction));
   assign pc_inc_s = pc_r + ADDR_WIDTH'(1);

   return_stack #(.DEPTH(STACK_DEPTH), .WIDTH(ADDR_WIDTH)) u_stack (
      .clk       (Clock),
      .rst       (Reset),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (pc_inc_s),
      .full      (stk_full_s),
      .empty     (stk_empty_s),
      .top       (stk_top_s)
   );

   // FSM state register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_r <= ST_FETCH;
      else       state_r <= state_next_s;
   end

   // FSM next-state logic; stack faults are terminal until reset
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_FETCH: begin
            if (iStall) begin
               state_next_s = ST_FETCH;
            end else begin
               case (opcode_s)
                  OPC_CALL: state_next_s = stk_full_s  ? ST_HALT : ST_FETCH;
                  OPC_RET:  state_next_s = stk_empty_s ? ST_HALT : ST_FETCH;
                  OPC_BLE:  state_next_s = ST_WAIT_BRANCH;
                  default:  state_next_s = ST_FETCH;
               endcase
            end
         end
         ST_WAIT_BRANCH: begin
            if (iBranchValid) state_next_s = ST_FETCH;
            else              state_next_s = ST_WAIT_BRANCH;
         end
         ST_HALT: state_next_s = ST_HALT;
         default: state_next_s = ST_HALT;
      endcase
   end

   // FSM datapath controls: next PC, stack ops, output load strobes
   always_comb begin
      pc_next_s    = pc_r;
      valid_next_s = 1'b0;
      instr_load_s = 1'b0;
      capture_s    = 1'b0;
      push_s       = 1'b0;
      pop_s        = 1'b0;
      ovf_set_s    = 1'b0;
      unf_set_s    = 1'b0;
      case (state_r)
         ST_FETCH: begin
            if (!iStall) begin
               case (opcode_s)
                  OPC_NOP: begin
                     pc_next_s    = pc_inc_s;
                     valid_next_s = 1'b1;
                     instr_load_s = 1'b1;
                  end
                  OPC_JMP: begin
                     pc_next_s    = target_s;
                     valid_next_s = 1'b1;
                     instr_load_s = 1'b1;
                  end
                  OPC_CALL: begin
                     if (stk_full_s) begin
                        ovf_set_s = 1'b1;
                     end else begin
                        push_s       = 1'b1;
                        pc_next_s    = target_s;
                        valid_next_s = 1'b1;
                        instr_load_s = 1'b1;
                     end
                  end
                  OPC_RET: begin
                     if (stk_empty_s) begin
                        unf_set_s = 1'b1;
                     end else begin
                        pop_s        = 1'b1;
                        pc_next_s    = stk_top_s;
                        valid_next_s = 1'b1;
                        instr_load_s = 1'b1;
                     end
                  end
                  OPC_BLE: begin
                     capture_s    = 1'b1;
                     valid_next_s = 1'b1;
                     instr_load_s = 1'b1;
                  end
                  default: begin
                     pc_next_s    = pc_inc_s;
                     valid_next_s = 1'b1;
                     instr_load_s = 1'b1;
                  end
               endcase
            end else begin
               pc_next_s = pc_r;
            end
         end
         ST_WAIT_BRANCH: begin
            if (iBranchValid) pc_next_s = iBranchTaken ? br_target_r : br_fall_r;
            else              pc_next_s = pc_r;
         end
         ST_HALT: pc_next_s = pc_r;
         default: pc_next_s = pc_r;
      endcase
   end

   // PC, fetched instruction, pending branch and sticky fault registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pc_r        <= ADDR_WIDTH'(0);
         valid_r     <= 1'b0;
         instr_r     <= INSTR_W'(0);
         br_target_r <= ADDR_WIDTH'(0);
         br_fall_r   <= ADDR_WIDTH'(0);
         ovf_r       <= 1'b0;
         unf_r       <= 1'b0;
      end else begin
         pc_r    <= pc_next_s;
         valid_r <= valid_next_s;
         ovf_r   <= ovf_r | ovf_set_s;
         unf_r   <= unf_r | unf_set_s;
         if (instr_load_s) instr_r <= iInstruction;
         else              instr_r <= instr_r;
         if (capture_s) begin
            br_target_r <= target_s;
            br_fall_r   <= pc_inc_s;
         end else begin
            br_target_r <= br_target_r;
            br_fall_r   <= br_fall_r;
         end
      end
   end

   assign oAddress        = pc_r;
   assign oInstruction    = instr_r;
   assign oValid          = valid_r;
   assign oStackOverflow  = ovf_r;
   assign oStackUnderflow = unf_r;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter STACK_DEPTH, default 8, giving the return-address stack entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, giving the program-counter width.
REQ-003 Clock  input  1  single system clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 oAddress  output  ADDR_WIDTH  current PC, driven to the instruction ROM address input.
REQ-006 iInstruction  input  28  ROM data for oAddress (combinational ROM): [27:24] opcode, [23:16] destination/target, [15:8] src1, [7:0] src0.
REQ-007 iStall  input  1  downstream cannot accept an instruction this cycle.
REQ-008 iBranchValid  input  1  single-cycle pulse from execute: BLE comparison resolved.
REQ-009 iBranchTaken  input  1  BLE result, qualified by iBranchValid.
REQ-010 oInstruction  output  28  registered fetched instruction to decode.
REQ-011 oValid  output  1  oInstruction is new and must be executed this cycle.
REQ-012 oStackOverflow  output  1  sticky; CALL attempted with stack full.
REQ-013 oStackUnderflow  output  1  sticky; RET attempted with stack empty.

Function
REQ-014 The block SHALL implement states FETCH, WAIT_BRANCH, HALT.
REQ-015 In FETCH with iStall=0, it SHALL register iInstruction into oInstruction, assert oValid for one cycle, and load the next PC per REQ-016..020.
REQ-016 Opcode JMP: next PC SHALL be {zeros, iInstruction[23:16]}.
REQ-017 Opcode CALL: it SHALL push PC+1 onto the stack and load next PC = {zeros, iInstruction[23:16]}.
REQ-018 Opcode RET: it SHALL pop the top stack entry into PC.
REQ-019 Opcode BLE: it SHALL capture target {zeros, iInstruction[23:16]} and fall-through PC+1, forward BLE with oValid=1, and go to WAIT_BRANCH.
REQ-020 Any other opcode, including NOP and undefined codes: next PC SHALL be PC+1, wrapping from all-ones to 0.
REQ-021 In WAIT_BRANCH, oValid SHALL be 0 every cycle; on iBranchValid=1, PC SHALL load the captured target if iBranchTaken=1 else fall-through, and the state SHALL return to FETCH.
REQ-022 iBranchValid SHALL be accepted in WAIT_BRANCH regardless of iStall, and ignored in FETCH and HALT.
REQ-023 With iStall=1 in FETCH, PC, stack, oInstruction SHALL hold and oValid SHALL be 0.
REQ-024 Fetch latency SHALL be one cycle: an instruction at PC=n appears on oInstruction the edge after oAddress=n.
REQ-025 CALL with stack full SHALL NOT push; it SHALL set oStackOverflow, drop the instruction (oValid=0), and enter HALT.
REQ-026 RET with stack empty SHALL set oStackUnderflow, drop the instruction (oValid=0), and enter HALT.
REQ-027 HALT SHALL hold PC, keep oValid=0, and exit only via Reset.
REQ-028 Nested CALLs up to STACK_DEPTH deep SHALL return in LIFO order.

Reset
REQ-029 Reset SHALL asynchronously set PC=0, state=FETCH, stack pointer=0 (empty), oInstruction=0, oValid=0, oStackOverflow=0, oStackUnderflow=0.
REQ-030 Reset asserted mid-WAIT_BRANCH or mid-HALT SHALL discard the pending branch and stack contents; first fetch after release SHALL be address 0.

Structure
REQ-031 Opcode constants (NOP, JMP, CALL, RET, BLE) and instruction field positions SHALL come from the shared definitions header; no local copies.
REQ-032 The return-address stack SHALL be a sub-module return_stack (push, pop, full, empty, top), instantiated once.
REQ-033 The ROM SHALL remain external; this block contains no program storage.

Verification
REQ-034 Reset release, ROM returning NOP everywhere -> oAddress 0,1,2,3 on consecutive cycles; oValid=1 from second cycle on.
REQ-035 CALL 17 at PC 5, RET at PC 20 -> oAddress sequence 5,17,18,19,20,6; stack empty afterward.
REQ-036 BLE target 17 at PC 19, iBranchValid pulse 3 cycles later with iBranchTaken=1, then rerun with 0 -> next oAddress 17, then 20; oValid=0 during the wait.
REQ-037 Nine nested CALLs with STACK_DEPTH=8 -> ninth sets oStackOverflow=1, oValid=0, PC frozen until Reset.
REQ-038 RET at PC 0 with empty stack -> oStackUnderflow=1, HALT; Reset pulse clears both flags and restarts at 0.
REQ-039 iStall held 4 cycles during straight-line fetch -> oAddress and oInstruction constant, oValid=0, no skipped or duplicated instruction after release.
